// File: rtl/regbank8_16bit.sv
// Eight-entry register bank: R0 reads as zero, R1-R7 writable, two combinational read ports.
// Optional write-through forwarding is enabled by defining REGBANK_BYPASS_EN.
module regbank8_16bit #(
    parameter int unsigned           WIDTH     = 16,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [2:0]       wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [2:0]       ra_i,
    input  logic [2:0]       rb_i,
    output logic [WIDTH-1:0] qa_o,
    output logic [WIDTH-1:0] qb_o,
    output logic [7:0]       valid_o
);

    logic [WIDTH-1:0] regs_q [1:7];
    logic [WIDTH-1:0] regs_d [1:7];
    logic [7:1]       valid_q;
    logic [7:1]       valid_d;
    logic             wr_en;

    // Writes to R0 are dropped here, so R0 never needs storage.
    assign wr_en = we_i && (wa_i != 3'd0);

    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        for (int i = 1; i < 8; i++) begin
            if (wr_en && (wa_i == 3'(i))) begin
                regs_d[i]  = wd_i;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        qa_o = '0;
        qb_o = '0;
        for (int i = 1; i < 8; i++) begin
            if (ra_i == 3'(i)) qa_o = regs_q[i];
            if (rb_i == 3'(i)) qb_o = regs_q[i];
        end
`ifdef REGBANK_BYPASS_EN
        // Forward the in-flight write so the next stage sees it this cycle.
        if (!rst_i && wr_en && (wa_i == ra_i)) qa_o = wd_i;
        if (!rst_i && wr_en && (wa_i == rb_i)) qb_o = wd_i;
`endif
    end

    assign valid_o = {valid_q, 1'b1};

endmodule

// File: tb/tb_regbank8_16bit.sv
// Randomised self-checking bench for regbank8_16bit against an array-based reference model.
module tb_regbank8_16bit;

    logic        clk = 1'b0;
    logic        rst, we;
    logic [2:0]  wa, ra, rb;
    logic [15:0] wd;
    logic [15:0] qa, qb;
    logic [7:0]  valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl [8];
    logic [7:0]  mvalid;

    always #5 clk = ~clk;

    regbank8_16bit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we),
        .wa_i    (wa),
        .wd_i    (wd),
        .ra_i    (ra),
        .rb_i    (rb),
        .qa_o    (qa),
        .qb_o    (qb),
        .valid_o (valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] sel);
        if (sel == 3'd0) return 16'h0000;
`ifdef REGBANK_BYPASS_EN
        if (!rst && we && wa != 3'd0 && wa == sel) return wd;
`endif
        return mdl[sel];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mvalid = 8'h01;
    endtask

    // Drive one cycle, check combinational outputs before the edge, then advance the model.
    task automatic cycle(input logic r, input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic [2:0] x, input logic [2:0] y, input string tag);
        rst = r; we = w; wa = a; wd = d; ra = x; rb = y;
        #2;
        check_eq({tag, ".qa"}, 32'(qa), 32'(exp_read(x)));
        check_eq({tag, ".qb"}, 32'(qb), 32'(exp_read(y)));
        check_eq({tag, ".valid"}, 32'(valid), 32'(mvalid));
        @(posedge clk);
        if (r) model_reset();
        else if (w && a != 3'd0) begin
            mdl[a]    = d;
            mvalid[a] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset beats a simultaneous write.
        cycle(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, "rst_wr");
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, "rst_chk");
        check_eq("rst_valid", 32'(valid), 32'h01);

        for (int n = 1; n < 8; n++)
            cycle(1'b0, 1'b1, 3'(n), 16'(16'h1111 * n), 3'(n - 1), 3'(n), "fill");
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "sweep");
        check_eq("fill_valid", 32'(valid), 32'hFF);
        check_eq("fill_r4", 32'(mdl[4]), 32'h4444);

        cycle(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "r0_wr");
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, "r0_rd");

        cycle(1'b0, 1'b1, 3'd5, 16'h0055, 3'd1, 3'd2, "raw_pre");
        cycle(1'b0, 1'b1, 3'd5, 16'hA5A5, 3'd5, 3'd5, "raw_same");
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, "raw_next");

        cycle(1'b0, 1'b1, 3'd2, 16'h1234, 3'd0, 3'd0, "dp_w2");
        cycle(1'b0, 1'b1, 3'd6, 16'h8001, 3'd0, 3'd0, "dp_w6");
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd6, "dp_rd");
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, "dp_same");

        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom), "rand");

        for (int n = 1; n < 8; n++)
            cycle(1'b0, 1'b1, 3'(n), 16'($urandom), 3'($urandom), 3'($urandom), "load");
        cycle(1'b1, 1'b1, 3'($urandom_range(1, 7)), 16'($urandom), 3'd1, 3'd2, "rst_mid");
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(i), "post_rst");
        check_eq("post_rst_valid", 32'(valid), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank8_16bit.md
# regbank8_16bit

Eight-entry, 16-bit general-purpose register bank for the RISC16bit datapath. It sits directly upstream of the 8-to-1 16-bit operand multiplexers: it holds R0–R7, accepts one write per clock from the writeback path, and presents two read ports whose 3-bit selects carry the same encoding as the mux select S (0 = R0 … 7 = R7). R0 is hardwired to zero. A per-register valid mask reports which registers have been written since reset.

## Interface
- `WIDTH`, default 16: data width of every register and data port.
- `RESET_VAL`, default 16'h0000: value loaded into R1–R7 on reset.
- `CLK`  in  1: rising-edge clock, the only clock in the block.
- `RST`  in  1: synchronous, active-high reset, sampled on the `CLK` rising edge.
- `WE`  in  1: write enable.
- `WA`  in  3: write address.
- `WD`  in  WIDTH: write data.
- `RA`  in  3: read-port A select.
- `RB`  in  3: read-port B select.
- `QA`  out  WIDTH: read-port A data.
- `QB`  out  WIDTH: read-port B data.
- `VALID`  out  8: bit n = 1 when Rn has been written since the last reset.

## Operation
- Storage: seven WIDTH-bit registers, R1–R7. R0 has no storage.
- Write: on a `CLK` rising edge with `WE`=1, `RST`=0 and `WA`≠0, R[`WA`] ← `WD` and `VALID[WA]` ← 1. All other registers hold.
- Write to R0 (`WA`=0 with `WE`=1): the write is discarded and no state changes.
- Read:
  - `QA` = R[`RA`] and `QB` = R[`RB`], both combinational from the selects.
  - A select of 0 always returns 16'h0000.
  - `RA` = `RB` is legal; both ports then return the same value.
- `VALID[0]` is constant 1. `VALID[7:1]` is sticky until reset.
- Reset:
  - On an edge with `RST`=1, R1–R7 ← `RESET_VAL` and `VALID` ← 8'b0000_0001.
  - Reset takes priority over a simultaneous write; the write is lost.
- Reset mid-operation: a write asserted in the same cycle as `RST` has no effect. A write in the first cycle after `RST` deasserts completes normally.
- `WA`, `RA` and `RB` are all 3 bits wide, so every encoding maps to a register and no out-of-range case exists.

## Timing
- Write latency: 1 clock. A value written at edge N is visible on `QA`/`QB` after edge N (readable in cycle N+1) when bypass is compiled out.
- Read latency: 0 clocks (combinational, select to data).
- `VALID` updates on the same edge as the register it tracks.
- Output values after reset: `QA`/`QB` = 0 when the select is 0, otherwise `RESET_VAL`; `VALID` = 8'h01.
- There is no handshake and no stall. `WE` is a single-cycle qualifier, so back-to-back writes every cycle are allowed.
- Two consecutive writes to the same address: the last one wins.

## Configuration
- Macro: `REGBANK_BYPASS_EN`.
- Defined: write-through forwarding is added.
  - Condition: `WE`=1, `RST`=0, `WA`≠0 and `WA`=`RA`.
  - Result: `QA` = `WD` combinationally in the same cycle. The same rule applies to `RB`/`QB`.
  - Effect: the following stage sees the new value without a one-cycle hazard.
- Undefined: no forwarding. Reads always return the stored value, and same-cycle read-after-write returns the old contents.
- The macro has no effect on reads of R0 or on cycles where `RST`=1.

## Test plan
- Reset: assert `RST` for 1 cycle with `WE`=1, `WA`=3, `WD`=16'hBEEF → `VALID`=8'h01; `QA` with `RA`=3 reads 16'h0000; R3 is not written.
- Fill and read-back: write Rn ← 16'h1111·n for n=1..7 on consecutive cycles, then sweep `RA` and `RB` 0..7 → each port reads 16'h0000 for select 0 and 16'h1111·n otherwise; `VALID`=8'hFF.
- R0 protection: `WE`=1, `WA`=0, `WD`=16'hFFFF, then `RA`=0 → `QA`=16'h0000; `VALID` is unchanged.
- Read-after-write in the same cycle: R5=16'h0055, then `WE`=1, `WA`=5, `WD`=16'hA5A5, `RA`=5 → `QA`=16'hA5A5 in that cycle with `REGBANK_BYPASS_EN` defined, 16'h0055 without it; 16'hA5A5 in the next cycle in both builds.
- Dual-port and same-address reads: R2=16'h1234, R6=16'h8001, with `RA`=2, `RB`=6 → `QA`=16'h1234, `QB`=16'h8001; with `RA`=`RB`=6 → both ports read 16'h8001.
- Reset after traffic: registers loaded with random `$random` values, then `RST` pulsed while `WE`=1 → every register reads `RESET_VAL` on the next cycle; `VALID`=8'h01.
